// File: rtl/clk_div_arb.sv
// Round-robin arbiter that time-shares one programmable clock divider: loads the
// winner's divide value under divider reset, runs it for N divided edges, then parks it.
module clk_div_arb #(
   parameter int NREQ   = 4,
   parameter int DW     = 8,
   parameter int CW     = 8,
   parameter int SETTLE = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*DW-1:0] req_div,
   input  logic [NREQ*CW-1:0] req_cnt,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [DW-1:0]     div_num,
   output logic              div_rst_n,
   input  logic              div_clk
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RELEASE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   winner_q, winner_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   edge_cnt_q, edge_cnt_d;
   logic [CW-1:0]   target_q, target_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic            div_q;
   logic [NREQ-1:0] gnt_d, done_d;
   logic [DW-1:0]   div_num_d;
   logic            div_rst_n_d;

   logic [DW-1:0]   div_arr [NREQ];
   logic [CW-1:0]   cnt_arr [NREQ];
   logic [IW-1:0]   pick, idx, next_ptr;
   logic            found, rise;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign div_arr[g] = req_div[g*DW +: DW];
      assign cnt_arr[g] = req_cnt[g*CW +: CW];
   end

   // div_q only tracks div_clk while the divider is running, so the first
   // edge after release is always seen as a rise.
   assign rise     = div_clk & ~div_q;
   assign busy     = (state_q != IDLE);
   assign next_ptr = (winner_q == IW'(NREQ - 1)) ? '0 : winner_q + IW'(1);

   // First pending request at or above the pointer, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = IW'((int'(ptr_q) + i) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      winner_d    = winner_q;
      ptr_d       = ptr_q;
      edge_cnt_d  = edge_cnt_q;
      target_d    = target_q;
      settle_d    = settle_q;
      gnt_d       = gnt;
      done_d      = '0;
      div_num_d   = div_num;
      div_rst_n_d = div_rst_n;

      unique case (state_q)
         IDLE: begin
            div_rst_n_d = 1'b0;
            if (found) begin
               state_d       = LOAD;
               winner_d      = pick;
               gnt_d         = '0;
               gnt_d[pick]   = 1'b1;
               div_num_d     = div_arr[pick];
               target_d      = cnt_arr[pick];
               edge_cnt_d    = '0;
               settle_d      = '0;
            end
         end
         LOAD: begin
            if (!req[winner_q]) begin
               state_d     = RELEASE;
               gnt_d       = '0;
               div_rst_n_d = 1'b0;
               ptr_d       = next_ptr;
            end else if (settle_q == SW'(SETTLE - 1)) begin
               if (target_q == '0) begin
                  state_d          = RELEASE;
                  gnt_d            = '0;
                  done_d[winner_q] = 1'b1;
                  ptr_d            = next_ptr;
               end else begin
                  state_d     = RUN;
                  div_rst_n_d = 1'b1;
               end
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         RUN: begin
            // Completion is checked before abort so a coinciding drop still reports done.
            if (rise && edge_cnt_q == target_q - CW'(1)) begin
               state_d          = RELEASE;
               gnt_d            = '0;
               div_rst_n_d      = 1'b0;
               done_d[winner_q] = 1'b1;
               ptr_d            = next_ptr;
            end else if (!req[winner_q]) begin
               state_d     = RELEASE;
               gnt_d       = '0;
               div_rst_n_d = 1'b0;
               ptr_d       = next_ptr;
            end else if (rise) begin
               edge_cnt_d = edge_cnt_q + CW'(1);
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         winner_q   <= '0;
         ptr_q      <= '0;
         edge_cnt_q <= '0;
         target_q   <= '0;
         settle_q   <= '0;
         div_q      <= 1'b0;
         gnt        <= '0;
         done       <= '0;
         div_num    <= '0;
         div_rst_n  <= 1'b0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         ptr_q      <= ptr_d;
         edge_cnt_q <= edge_cnt_d;
         target_q   <= target_d;
         settle_q   <= settle_d;
         div_q      <= div_rst_n & div_clk;
         gnt        <= gnt_d;
         done       <= done_d;
         div_num    <= div_num_d;
         div_rst_n  <= div_rst_n_d;
      end
   end

endmodule

// File: tb/tb_clk_div_arb.sv
// Directed bench for clk_div_arb: div_clk is driven by hand so every edge count
// and latency below is computed cycle by cycle.
module tb_clk_div_arb;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] req_div;
   logic [31:0] req_cnt;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        busy;
   logic [7:0]  div_num;
   logic        div_rst_n;
   logic        div_clk;

   int vectors     = 0;
   int miscompares = 0;
   int order [5]   = '{0, 1, 2, 3, 0};
   logic [7:0] prev_div_num = '0;

   clk_div_arb #(.NREQ(4), .DW(8), .CW(8), .SETTLE(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_div   (req_div),
      .req_cnt   (req_cnt),
      .gnt       (gnt),
      .done      (done),
      .busy      (busy),
      .div_num   (div_num),
      .div_rst_n (div_rst_n),
      .div_clk   (div_clk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // The divide value must never move while the divider is running.
   always @(negedge clk) begin
      if (rst_n && div_rst_n) check("div_num_stable", 32'(div_num), 32'(prev_div_num));
      prev_div_num = div_num;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; req = '0; req_div = '0; req_cnt = '0; div_clk = 1'b0;
      #2;
      check("rst_gnt",       32'(gnt),       32'h0);
      check("rst_done",      32'(done),      32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      check("rst_div_num",   32'(div_num),   32'h0);
      check("rst_div_rst_n", 32'(div_rst_n), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      check("idle_busy", 32'(busy), 32'h0);

      // Single request: div 3, two edges.
      req_div[7:0] = 8'd3; req_cnt[7:0] = 8'd2; req = 4'b0001;
      step();
      check("t1_gnt",      32'(gnt),       32'h1);
      check("t1_div_num",  32'(div_num),   32'h3);
      check("t1_load_rst", 32'(div_rst_n), 32'h0);
      check("t1_busy",     32'(busy),      32'h1);
      step();
      check("t1_settle_rst", 32'(div_rst_n), 32'h0);
      step();
      check("t1_run_rst", 32'(div_rst_n), 32'h1);
      div_clk = 1'b1; req_div[7:0] = 8'd7;
      step();
      check("t1_no_done_early", 32'(done),    32'h0);
      check("t1_cfg_stable",    32'(div_num), 32'h3);
      div_clk = 1'b0;
      step();
      div_clk = 1'b1;
      step();
      check("t1_done",     32'(done),      32'h1);
      check("t1_gnt_off",  32'(gnt),       32'h0);
      check("t1_rel_rst",  32'(div_rst_n), 32'h0);
      req = '0; div_clk = 1'b0;
      step();
      check("t1_done_pulse", 32'(done),      32'h0);
      check("t1_idle_busy",  32'(busy),      32'h0);
      check("t1_hold_num",   32'(div_num),   32'h3);
      check("t1_idle_rst",   32'(div_rst_n), 32'h0);

      // Zero count: requester 2 completes straight out of LOAD.
      req_div[23:16] = 8'd5; req_cnt[23:16] = 8'd0; req = 4'b0100;
      step();
      check("t2_gnt1", 32'(gnt),       32'h4);
      check("t2_num",  32'(div_num),   32'h5);
      check("t2_rst1", 32'(div_rst_n), 32'h0);
      step();
      check("t2_gnt2",  32'(gnt),       32'h4);
      check("t2_done0", 32'(done),      32'h0);
      check("t2_rst2",  32'(div_rst_n), 32'h0);
      step();
      check("t2_done", 32'(done),      32'h4);
      check("t2_gnt0", 32'(gnt),       32'h0);
      check("t2_rst3", 32'(div_rst_n), 32'h0);
      req = '0;
      step();
      check("t2_idle", 32'(busy), 32'h0);

      // Abort: pointer is at 3, so requester 1 wins over 2; drop it after one edge.
      req_div[15:8] = 8'd4; req_cnt[15:8] = 8'd5;
      req_div[23:16] = 8'd6; req_cnt[23:16] = 8'd3;
      req = 4'b0110;
      step();
      check("t3_gnt",  32'(gnt),     32'h2);
      check("t3_num",  32'(div_num), 32'h4);
      step();
      step();
      check("t3_run_rst", 32'(div_rst_n), 32'h1);
      div_clk = 1'b1;
      step();
      check("t3_no_done", 32'(done), 32'h0);
      check("t3_gnt_run", 32'(gnt),  32'h2);
      div_clk = 1'b0; req = 4'b0100;
      step();
      check("t3_abort_gnt",  32'(gnt),       32'h0);
      check("t3_abort_rst",  32'(div_rst_n), 32'h0);
      check("t3_abort_done", 32'(done),      32'h0);
      check("t3_abort_busy", 32'(busy),      32'h1);
      step();
      check("t3_idle_done", 32'(done), 32'h0);
      check("t3_idle_busy", 32'(busy), 32'h0);
      step();
      check("t3_next_gnt", 32'(gnt),     32'h4);
      check("t3_next_num", 32'(div_num), 32'h6);

      // Reset mid-RUN with requester 3 pending.
      req_div[31:24] = 8'd9; req_cnt[31:24] = 8'd1; req = 4'b1100;
      step();
      step();
      check("t4_run_rst", 32'(div_rst_n), 32'h1);
      div_clk = 1'b1;
      step();
      check("t4_no_done", 32'(done), 32'h0);
      rst_n = 1'b0;
      #1;
      check("t4_async_gnt",  32'(gnt),       32'h0);
      check("t4_async_done", 32'(done),      32'h0);
      check("t4_async_busy", 32'(busy),      32'h0);
      check("t4_async_num",  32'(div_num),   32'h0);
      check("t4_async_rst",  32'(div_rst_n), 32'h0);
      req = 4'b1000; div_clk = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check("t4_gnt3", 32'(gnt),     32'h8);
      check("t4_num3", 32'(div_num), 32'h9);
      step();
      step();
      check("t4_run3", 32'(div_rst_n), 32'h1);
      div_clk = 1'b1;
      step();
      check("t4_done3", 32'(done), 32'h8);
      check("t4_gnt0",  32'(gnt),  32'h0);
      req = '0; div_clk = 1'b0;
      step();
      check("t4_idle", 32'(busy), 32'h0);

      // Fairness: all four held, one edge each, pointer back at 0.
      req_cnt = {4{8'd1}};
      req_div = {8'd5, 8'd4, 8'd3, 8'd2};
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("t5_gnt_%0d", k), 32'(gnt),     32'(1) << order[k]);
         check($sformatf("t5_num_%0d", k), 32'(div_num), 32'(order[k] + 2));
         step();
         step();
         check($sformatf("t5_run_%0d", k), 32'(div_rst_n), 32'h1);
         div_clk = 1'b1;
         step();
         check($sformatf("t5_done_%0d", k), 32'(done), 32'(1) << order[k]);
         check($sformatf("t5_rel_%0d", k),  32'(gnt),  32'h0);
         div_clk = 1'b0;
         if (k == 4) req = '0;
         step();
         check($sformatf("t5_idle_%0d", k), 32'(busy), 32'h0);
      end

      // Final edge coincides with the request dropping: completion wins.
      req = 4'b0010;
      step();
      check("t6_gnt", 32'(gnt), 32'h2);
      step();
      step();
      check("t6_run", 32'(div_rst_n), 32'h1);
      div_clk = 1'b1; req = '0;
      step();
      check("t6_done", 32'(done), 32'h2);
      div_clk = 1'b0;
      step();
      check("t6_idle", 32'(busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clk_div_arb.md
Name: clk_div_arb

Overview:
- Round-robin arbiter and sequencer that shares one programmable clock divider between NREQ requesters.
- Each requester asks for a divide value and a number of divided-clock periods.
- The block grants one requester at a time and loads its divide value while holding the divider in reset. It then releases the divider, counts rising edges of the divider output, and returns the divider to reset when the count is reached.
- Sits between client blocks and the divider instance: drives the divider's div_num and rst_n, and observes its clk_out.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, width of divide value (matches divider div_num)
- CW, 8, width of requested period count
- SETTLE, 2, cycles the divider is held in reset after div_num changes (>=1)

Ports:
- clk  in  1  system clock; the divider runs on the same clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level; held until done, or dropped to abort
- req_div  in  NREQ*DW  divide value, slice i belongs to requester i
- req_cnt  in  NREQ*CW  number of divider rising edges to run, slice i for requester i
- gnt  out  NREQ  one-hot grant, registered
- done  out  NREQ  one-cycle completion pulse to the granted requester, registered
- busy  out  1  high in any state other than IDLE
- div_num  out  DW  divide value to the divider, registered
- div_rst_n  out  1  active-low reset to the divider, registered
- div_clk  in  1  divider clk_out, synchronous to clk

Behaviour:
- Reset values: gnt=0, done=0, busy=0, div_num=0, div_rst_n=0, rr pointer=0, edge counter=0, state=IDLE.
- Reset is asynchronous. Asserting it mid-operation aborts immediately, with no done pulse.
- States: IDLE, LOAD, RUN, RELEASE.
- IDLE:
  - div_rst_n=0; div_num holds its last value.
  - If any req is high, pick the first set bit searching from the pointer upward, modulo NREQ.
  - Next cycle: enter LOAD, set gnt[winner]=1, div_num=req_div[winner], latch target=req_cnt[winner], clear the edge counter.
- LOAD:
  - Lasts exactly SETTLE cycles, with div_rst_n=0.
  - At the end: if target==0, go to RELEASE. Otherwise go to RUN with div_rst_n=1.
- RUN:
  - Edge detect: div_q <= div_clk; rise = div_clk & ~div_q.
  - div_q is forced to 0 while div_rst_n=0.
  - Each rise increments the edge counter.
  - When rise occurs with counter==target-1, go to RELEASE.
- RELEASE (1 cycle):
  - done[winner]=1 (not on abort), gnt=0, div_rst_n=0.
  - Pointer = (winner+1) mod NREQ.
  - Next state is IDLE.
- Abort: req[winner] low in LOAD or RUN.
  - Next cycle enters RELEASE with done suppressed.
  - gnt=0 and div_rst_n=0 in that cycle; the pointer still advances.
- div_num changes only on the IDLE->LOAD transition. It is never changed while div_rst_n=1, which keeps the switch glitch-free.
- Latency:
  - req high in IDLE at cycle N gives gnt at N+1.
  - div_rst_n rises at N+1+SETTLE.
  - done arrives 1 cycle after the target-th rising edge.
  - Back-to-back grants are separated by RELEASE plus IDLE: new gnt no earlier than 2 cycles after done.
- Width rules: the counter is CW bits and never wraps, because target<=2^CW-1. req_div and req_cnt are sampled only at grant; later changes are ignored.
- Simultaneous events: when the final rise coincides with abort, completion wins and done is pulsed.
- Requests arriving in LOAD, RUN or RELEASE wait; there is no preemption.
- busy = (state != IDLE).

Test Plan:
- Single request, req[0]=1, req_div=3, req_cnt=2 at cycle 0:
  - gnt=0001 at 1, div_num=3 at 1, div_rst_n=1 at 3.
  - done[0] pulses 1 cycle after the 2nd div_clk rise; gnt=0 in the same cycle.
  - div_rst_n=0 thereafter.
- Fairness, all four req held with req_cnt=1: grant order 0,1,2,3,0.
  - Each gnt is one-hot; gnt is never high in two consecutive transactions for the same index while others wait.
- Zero count, req[2]=1, req_cnt=0:
  - gnt=0100 for SETTLE cycles, then done[2] pulse.
  - div_rst_n never rises.
- Abort, req[1] dropped mid-RUN after 1 of 5 edges:
  - Next cycle gnt=0, div_rst_n=0, no done pulse.
  - Next grant goes to requester 2 if pending.
- Reset mid-RUN with rst_n low for 1 cycle:
  - All outputs go to reset values asynchronously.
  - After release, a pending req[3] is granted 1 cycle later, since the pointer is back at 0 and only req[3] is pending.
- Config stability:
  - Change req_div[0] during RUN: div_num is unchanged until the next grant.
  - Assert that div_num never changes while div_rst_n=1.
